// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate-generation stage.
//   fmt_e       3-bit immediate format code
//   OP_*        RV32I/RV64I major opcodes that carry (or lack) an immediate
//   F3_*        funct3 values that turn OP-IMM into a shift
//   shamt_w()   shift-amount field width for a given XLEN
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_SH  = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  function automatic int shamt_w(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake/data bundle of the immediate stage.
//   upstream side  : flush_i, in_valid_i, in_ready_o, instr_i, pc_i
//   downstream side: out_valid_o, out_ready_i, imm_o, fmt_o, illegal_o,
//                    pc_o, target_o
//   modport slave  : the stage itself; modport master: whoever drives it.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  import imm_pkg::*;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  fmt_e             fmt_o;
  logic             illegal_o;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  target_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, pc_o, target_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, pc_o, target_o
  );

endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate decoder.
//   instr_i    raw 32-bit instruction
//   imm_o      immediate extended to XLEN
//   fmt_o      format code
//   illegal_o  opcode not recognised (imm_o forced to 0)
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  localparam int SHAMT_W = shamt_w(XLEN);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Size casts of $signed() operands give the sign extension to XLEN.
  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          // funct7 (including the SRA select bit) is deliberately left out.
          imm_o = XLEN'(instr_i[20 +: SHAMT_W]);
          fmt_o = FMT_SH;
        end else begin
          imm_o = XLEN'($signed(instr_i[31:20]));
          fmt_o = FMT_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        imm_o = XLEN'($signed(instr_i[31:20]));
        fmt_o = FMT_I;
      end
      OP_STORE: begin
        imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        fmt_o = FMT_S;
      end
      OP_BRANCH: begin
        imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0}));
        fmt_o = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
        fmt_o = FMT_U;
      end
      OP_JAL: begin
        imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0}));
        fmt_o = FMT_J;
      end
      OP_REG: begin
        fmt_o = FMT_R;
      end
      default: begin
        fmt_o     = FMT_BAD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate-generation stage with skid buffer.
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     imm_gen_pipe_if.slave (upstream beat in, decoded beat out)
// Decode and target add happen before the registers, so the main and skid
// entries hold finished results. in_ready_o is the inverse of the skid flag,
// a flop, so out_ready_i never reaches it combinationally.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } beat_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (bus.instr_i),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  beat_t in_beat;
  beat_t main_d, main_q;
  beat_t skid_d, skid_q;
  logic  main_valid_d, main_valid_q;
  logic  skid_valid_d, skid_valid_q;
  logic  accept;
  logic  main_free;

  always_comb begin
    in_beat.imm     = dec_imm;
    in_beat.fmt     = dec_fmt;
    in_beat.illegal = dec_illegal;
    in_beat.pc      = bus.pc_i;
    in_beat.target  = bus.pc_i + dec_imm;
  end

  assign accept    = bus.in_valid_i && !skid_valid_q;
  assign main_free = !main_valid_q || bus.out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // A full skid blocks accept, so the two refill sources never collide.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready_o  = !skid_valid_q;
  assign bus.out_valid_o = main_valid_q;
  assign bus.imm_o       = main_q.imm;
  assign bus.fmt_o       = main_q.fmt;
  assign bus.illegal_o   = main_q.illegal;
  assign bus.pc_o        = main_q.pc;
  assign bus.target_o    = main_q.target;

endmodule
